// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx among NUM_REQ byte streams.
// Optional stall timeout with forced grant release is enabled by defining UART_ARB_TIMEOUT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// ARB   | no owner; pick the next valid requester after last_owner
// XFER  | owner holds the grant until its req_last byte is accepted
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_byte,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   arb_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic {ARB, XFER} state_t;

    state_t               state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        last_owner;
    logic [IW-1:0]        next_idx;
    logic [IW-1:0]        cand;
    logic                 found;
    logic [NUM_REQ-1:0]   next_grant;
    logic                 owner_valid;
    logic                 owner_last;
    logic [7:0]           owner_byte;
    logic                 can_issue;
    logic                 accept;
    logic                 timeout_hit;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_owner) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    always_comb begin
        next_grant           = '0;
        next_grant[next_idx] = 1'b1;
    end

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign owner_byte  = req_data[{owner, 3'b000} +: 8];

    // tx_start blocks the cycle after an accept, before uart_tx has raised tx_busy.
    assign can_issue = (state == XFER) && !tx_busy && !tx_start;
    assign accept    = can_issue && owner_valid;

    always_comb begin
        req_ready = '0;
        if (can_issue) begin
            req_ready[owner] = 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] stall_cnt;

    assign timeout_hit = (state == XFER) && !owner_valid &&
                         (stall_cnt == CW'(TIMEOUT_CYC - 1));

    // Only an absent owner counts as a stall; waiting on tx_busy does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state != XFER || accept || timeout_hit) begin
            stall_cnt <= '0;
        end else if (!owner_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            owner       <= '0;
            last_owner  <= IW'(NUM_REQ - 1);
            grant       <= '0;
            tx_byte     <= 8'h00;
            tx_start    <= 1'b0;
            arb_timeout <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            arb_timeout <= 1'b0;
            case (state)
                ARB: begin
                    if (found) begin
                        owner <= next_idx;
                        grant <= next_grant;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        tx_byte  <= owner_byte;
                        tx_start <= 1'b1;
                        if (owner_last) begin
                            last_owner <= owner;
                            grant      <= '0;
                            state      <= ARB;
                        end
                    end else if (timeout_hit) begin
                        arb_timeout <= 1'b1;
                        last_owner  <= owner;
                        grant       <= '0;
                        state       <= ARB;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester message sources and a uart_tx busy model
// (10 bits x BAUD_DIV 3); transmitted bytes are logged and compared against hand-computed order.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int TIMEOUT  = 16;
    localparam int BUSY_LEN = 30;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [8*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    grant;
    logic [7:0]            tx_byte;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  arb_timeout;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_byte    (tx_byte),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    // message sources
    logic [7:0] src_mem [NUM_REQ][8];
    int         src_len [NUM_REQ];
    logic [3:0] src_ptr [NUM_REQ];
    logic       src_en  [NUM_REQ];
    logic       src_clr [NUM_REQ];

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[8*i +: 8] = src_mem[i][src_ptr[i][2:0]];
            req_valid[i]       = src_en[i] && (int'(src_ptr[i]) < src_len[i]);
            req_last[i]        = (int'(src_ptr[i]) == src_len[i] - 1);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_clr[i])
                src_ptr[i] <= '0;
            else if (req_valid[i] && req_ready[i])
                src_ptr[i] <= src_ptr[i] + 4'd1;
        end
    end

    // uart_tx model and protocol monitors
    int         busy_cnt = 0;
    logic       force_busy;
    logic [7:0] tx_log [$];
    int         viol_busy = 0;
    int         viol_dbl  = 0;
    logic       prev_start = 1'b0;

    assign tx_busy = (busy_cnt != 0) || force_busy;

    always @(posedge clk) begin
        if (tx_start)
            busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
        if (tx_start) tx_log.push_back(tx_byte);
        if (tx_start && tx_busy) viol_busy <= viol_busy + 1;
        if (tx_start && prev_start) viol_dbl <= viol_dbl + 1;
        prev_start <= tx_start;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_msg(input int r, input int len, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        src_en[r]     = 1'b0;
        src_mem[r][0] = b0;
        src_mem[r][1] = b1;
        src_mem[r][2] = b2;
        src_len[r]    = len;
        src_clr[r]    = 1'b1;
        @(negedge clk);
        src_clr[r]    = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n);
        int k = 0;
        while (tx_log.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (tx_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(tx_busy), 32'd0);
    endtask

    task automatic wait_accept(input string tag, input int r);
        int k = 0;
        while (!(req_valid[r] && req_ready[r]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(req_valid[r] && req_ready[r]), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_t1 [3];
    int base;
    int bad;
    int spur;
    int k;

    initial begin
        rst_n      = 1'b0;
        force_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_en[i]  = 1'b0;
            src_clr[i] = 1'b1;
            src_len[i] = 0;
            for (int j = 0; j < 8; j++) src_mem[i][j] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_tx_start", 32'(tx_start), 32'd0);
        check_val("rst_tx_byte", 32'(tx_byte), 32'h00);
        check_val("rst_arb_timeout", 32'(arb_timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) src_clr[i] = 1'b0;

        // 1: req0 sends a three-byte message
        exp_t1[0] = 8'h41; exp_t1[1] = 8'h42; exp_t1[2] = 8'h43;
        load_msg(0, 3, 8'h41, 8'h42, 8'h43);
        src_en[0] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_accept("t1_accept", 0);
            check_val("t1_grant_owner", 32'(grant), 32'b0001);
            @(negedge clk);
            check_val("t1_tx_start", 32'(tx_start), 32'd1);
            check_val("t1_tx_byte", 32'(tx_byte), 32'(exp_t1[b]));
            check_val("t1_ready_low", 32'(req_ready), 32'd0);
            if (b == 2) check_val("t1_grant_released", 32'(grant), 32'd0);
        end
        @(negedge clk);
        check_val("t1_three_starts", 32'(tx_log.size()), 32'd3);

        // 2: req0 and req2 together after reset; req0 re-requests during req2's message
        wait_idle("t2_idle");
        do_reset();
        load_msg(0, 2, 8'h10, 8'h11, 8'h00);
        load_msg(2, 2, 8'h20, 8'h21, 8'h00);
        base = tx_log.size();
        src_en[0] = 1'b1;
        src_en[2] = 1'b1;
        @(negedge clk);
        check_val("t2_first_grant", 32'(grant), 32'b0001);
        wait_log("t2_req0_done", base + 2);
        load_msg(0, 1, 8'h12, 8'h00, 8'h00);
        src_en[0] = 1'b1;
        check_val("t2_req2_owns", 32'(grant), 32'b0100);
        wait_log("t2_all", base + 5);
        check_val("t2_b0", 32'(tx_log[base]),     32'h10);
        check_val("t2_b1", 32'(tx_log[base + 1]), 32'h11);
        check_val("t2_b2", 32'(tx_log[base + 2]), 32'h20);
        check_val("t2_b3", 32'(tx_log[base + 3]), 32'h21);
        check_val("t2_b4", 32'(tx_log[base + 4]), 32'h12);

        // 3: message lock while owner req1 pauses for 50 cycles
        wait_idle("t3_idle");
        load_msg(1, 3, 8'h31, 8'h32, 8'h33);
        load_msg(3, 1, 8'h3a, 8'h00, 8'h00);
        base = tx_log.size();
        src_en[1] = 1'b1;
        wait_log("t3_first", base + 1);
        src_en[1] = 1'b0;
        src_en[3] = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (grant !== 4'b0010 || req_ready[3] !== 1'b0) bad++;
        end
        check_val("t3_lock_held", 32'(bad), 32'd0);
        check_val("t3_no_req3_byte", 32'(tx_log.size()), 32'(base + 1));
        src_en[1] = 1'b1;
        wait_log("t3_all", base + 4);
        check_val("t3_b1", 32'(tx_log[base + 1]), 32'h32);
        check_val("t3_b2", 32'(tx_log[base + 2]), 32'h33);
        check_val("t3_b3", 32'(tx_log[base + 3]), 32'h3a);

        // 4: tx_busy held for 100 cycles during XFER
        wait_idle("t4_idle");
        load_msg(2, 2, 8'h44, 8'h45, 8'h00);
        base = tx_log.size();
        force_busy = 1'b1;
        src_en[2]  = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (req_ready !== 4'b0000 || tx_start !== 1'b0) bad++;
        end
        check_val("t4_stalled", 32'(bad), 32'd0);
        check_val("t4_grant", 32'(grant), 32'b0100);
        check_val("t4_no_bytes", 32'(tx_log.size()), 32'(base));
        force_busy = 1'b0;
        #1;
        check_val("t4_ready_same_cycle", 32'(req_ready), 32'b0100);
        @(negedge clk);
        check_val("t4_tx_start_next", 32'(tx_start), 32'd1);
        check_val("t4_tx_byte", 32'(tx_byte), 32'h44);
        wait_log("t4_all", base + 2);
        check_val("t4_b1", 32'(tx_log[base + 1]), 32'h45);

        // 5: asynchronous reset in the middle of req3's message
        wait_idle("t5_idle");
        load_msg(0, 1, 8'h61, 8'h00, 8'h00);
        load_msg(3, 3, 8'h51, 8'h52, 8'h53);
        src_en[3] = 1'b1;
        k = 0;
        while (tx_start !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("t5_first_start", 32'(tx_start), 32'd1);
        src_en[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_rst_grant", 32'(grant), 32'd0);
        check_val("t5_rst_ready", 32'(req_ready), 32'd0);
        check_val("t5_rst_tx_start", 32'(tx_start), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = tx_log.size();
        @(negedge clk);
        check_val("t5_req0_wins", 32'(grant), 32'b0001);
        wait_log("t5_all", base + 3);
        check_val("t5_b0", 32'(tx_log[base]),     32'h61);
        check_val("t5_b1", 32'(tx_log[base + 1]), 32'h52);
        check_val("t5_b2", 32'(tx_log[base + 2]), 32'h53);

        // 6: owner req2 disappears mid-message
        wait_idle("t6_idle");
        load_msg(2, 2, 8'h71, 8'h72, 8'h00);
        load_msg(3, 1, 8'h81, 8'h00, 8'h00);
        base = tx_log.size();
        src_en[2] = 1'b1;
        wait_log("t6_first", base + 1);
        src_en[2] = 1'b0;
        src_en[3] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        k = 0;
        spur = 0;
        while (arb_timeout !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (tx_start) spur++;
        end
        check_val("t6_timeout_cycles", 32'(k), 32'd16);
        check_val("t6_grant_dropped", 32'(grant), 32'd0);
        @(negedge clk);
        if (tx_start) spur++;
        check_val("t6_single_pulse", 32'(arb_timeout), 32'd0);
        check_val("t6_grant_req3", 32'(grant), 32'b1000);
        check_val("t6_no_spurious_start", 32'(spur), 32'd0);
        wait_log("t6_req3", base + 2);
        check_val("t6_b1", 32'(tx_log[base + 1]), 32'h81);
        src_en[2] = 1'b1;
        wait_log("t6_req2_resume", base + 3);
        check_val("t6_b2", 32'(tx_log[base + 2]), 32'h72);
`else
        bad = 0;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            if (arb_timeout !== 1'b0) spur++;
            if (grant !== 4'b0100) bad++;
        end
        check_val("t6_no_timeout", 32'(spur), 32'd0);
        check_val("t6_grant_held", 32'(bad), 32'd0);
        src_en[2] = 1'b1;
        wait_log("t6_all", base + 3);
        check_val("t6_b1", 32'(tx_log[base + 1]), 32'h72);
        check_val("t6_b2", 32'(tx_log[base + 2]), 32'h81);
`endif

        wait_idle("end_idle");
        check_val("start_while_busy", 32'(viol_busy), 32'd0);
        check_val("back_to_back_start", 32'(viol_dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
